// File: rtl/phys_free_list.sv
// Physical-register free list for rename: circular buffer of free IDs with a
// speculative head for allocation and a committed head restored on flush.
module phys_free_list #(
  parameter int NUM_ARCH_REGS = 35,
  parameter int NUM_PHYS_REGS = 64,
  localparam int DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS,
  localparam int PW    = $clog2(NUM_PHYS_REGS),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_alloc_req,
  output logic          o_alloc_ok,
  output logic [PW-1:0] o_alloc_preg,
  input  logic          i_retire_alloc,
  input  logic          i_free_valid,
  input  logic [PW-1:0] i_free_preg,
  input  logic          i_flush,
  output logic          o_ready,
  output logic [CW-1:0] o_free_count,
  output logic          o_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_INIT    = 2'd0,
    S_RUN     = 2'd1,
    S_RECOVER = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_init_idx;
  logic [AW-1:0] r_spec_head;
  logic [AW-1:0] r_commit_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_spec_count;
  logic [CW-1:0] r_commit_count;
  logic          r_err;
  logic [PW-1:0] r_mem [0:DEPTH-1];

  logic          w_in_op;
  logic          w_alloc_ok;
  logic          w_alloc_do;
  logic          w_flush_do;
  logic          w_retire_bad;
  logic          w_retire_do;
  logic          w_free_range_bad;
  logic          w_free_full;
  logic          w_free_do;
  logic          w_free_drop;
  logic          w_init_last;
  logic [AW-1:0] w_commit_head_nxt;
  logic [CW-1:0] w_commit_count_nxt;
  logic [CW-1:0] w_spec_count_adv;

  // Pointer increment with explicit wrap; DEPTH is generally not a power of two.
  function automatic logic [AW-1:0] f_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_INIT;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_INIT:    if (w_init_last) w_state_nxt = S_RUN;
      S_RUN:     if (i_flush)     w_state_nxt = S_RECOVER;
      S_RECOVER: w_state_nxt = S_RUN;
      default:   w_state_nxt = S_INIT;
    endcase
  end

  assign w_in_op     = (r_state != S_INIT);
  assign w_init_last = (r_init_idx == AW'(DEPTH - 1));
  assign w_alloc_ok  = (r_state == S_RUN) && (r_spec_count != '0);
  assign w_alloc_do  = w_alloc_ok && i_alloc_req && !i_flush;
  assign w_flush_do  = (r_state == S_RUN) && i_flush;

  // A retire with nothing outstanding is ignored and flagged.
  assign w_retire_bad = w_in_op && i_retire_alloc && (r_commit_count == r_spec_count);
  assign w_retire_do  = w_in_op && i_retire_alloc && (r_commit_count != r_spec_count);

  // A same-cycle retire vacates the committed-head slot, so the push then fits.
  assign w_free_range_bad = (int'(i_free_preg) >= NUM_PHYS_REGS);
  assign w_free_full      = (r_commit_count == CW'(DEPTH)) && !w_retire_do;
  assign w_free_do        = w_in_op && i_free_valid && !w_free_range_bad && !w_free_full;
  assign w_free_drop      = w_in_op && i_free_valid && (w_free_range_bad || w_free_full);

  assign w_commit_head_nxt  = w_retire_do ? f_inc(r_commit_head) : r_commit_head;
  assign w_commit_count_nxt = r_commit_count + CW'(w_free_do) - CW'(w_retire_do);
  assign w_spec_count_adv   = r_spec_count + CW'(w_free_do) - CW'(w_alloc_do);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_init_idx     <= '0;
      r_spec_head    <= '0;
      r_commit_head  <= '0;
      r_tail         <= '0;
      r_spec_count   <= '0;
      r_commit_count <= '0;
      r_err          <= 1'b0;
    end else if (r_state == S_INIT) begin
      r_init_idx <= w_init_last ? '0 : r_init_idx + AW'(1);
      if (w_init_last) begin
        r_spec_head    <= '0;
        r_commit_head  <= '0;
        r_tail         <= '0;
        r_spec_count   <= CW'(DEPTH);
        r_commit_count <= CW'(DEPTH);
      end
    end else begin
      r_commit_head  <= w_commit_head_nxt;
      r_commit_count <= w_commit_count_nxt;
      if (w_free_do) r_tail <= f_inc(r_tail);
      // Flush rewinds the speculative view onto the post-retire committed view.
      if (w_flush_do) begin
        r_spec_head  <= w_commit_head_nxt;
        r_spec_count <= w_commit_count_nxt;
      end else begin
        if (w_alloc_do) r_spec_head <= f_inc(r_spec_head);
        r_spec_count <= w_spec_count_adv;
      end
      if (w_retire_bad || w_free_drop) r_err <= 1'b1;
    end
  end

  // ID storage carries data only and needs no reset; INIT seeds it.
  always_ff @(posedge i_clk) begin
    if (r_state == S_INIT)
      r_mem[r_init_idx] <= PW'(NUM_ARCH_REGS) + PW'(r_init_idx);
    else if (w_free_do)
      r_mem[r_tail] <= i_free_preg;
  end

  assign o_alloc_ok   = w_alloc_ok;
  assign o_alloc_preg = w_alloc_ok ? r_mem[r_spec_head] : '0;
  assign o_ready      = w_in_op;
  assign o_free_count = r_spec_count;
  assign o_err        = r_err;

endmodule
